// File: rtl/completion_writeback_buffer_pkg.sv
// Shared widths and slot-packing helpers for the completion writeback buffer.
package completion_writeback_buffer_pkg;

  localparam int PR_ADDR_W  = 5;
  localparam int CWB_DATA_W = 8;
  localparam int CWB_PR_W   = PR_ADDR_W;
  localparam int CWB_AR_W   = 4;
  localparam int CWB_ROB_W  = 5;

  function automatic int slot_idx(
    input int c,
    input int s,
    input int slots
  );
    return c * slots + s;
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/completion_writeback_buffer_fifo.sv
// One completion channel: in-order FWFT FIFO with flush and per-slot
// register-file write enables raised only on the ROB handshake.
module wb_channel_fifo
  import completion_writeback_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int SLOTS  = 2,
  parameter int DATA_W = CWB_DATA_W,
  parameter int PR_W   = CWB_PR_W,
  parameter int AR_W   = CWB_AR_W,
  parameter int ROB_W  = CWB_ROB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROB_W-1:0]         in_rob,
  input  logic [SLOTS-1:0]         in_wen,
  input  logic [SLOTS*PR_W-1:0]    in_preg,
  input  logic [SLOTS*AR_W-1:0]    in_areg,
  input  logic [SLOTS*DATA_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROB_W-1:0]         out_rob,
  output logic [SLOTS*PR_W-1:0]    out_preg,
  output logic [SLOTS*AR_W-1:0]    out_areg,
  output logic [SLOTS*DATA_W-1:0]  out_data,
  output logic [SLOTS-1:0]         rf_wen,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int E_W   = ROB_W + SLOTS * (1 + PR_W + AR_W + DATA_W);

  logic [E_W-1:0]   mem_q [DEPTH];
  logic [E_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SLOTS-1:0] head_wen;
  logic             push, pop;

  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign occupancy = cnt_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign {out_rob, head_wen, out_preg, out_areg, out_data} =
    mem_q[rd_ptr_q];

  assign rf_wen = {SLOTS{pop}} & head_wen;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      // empty by catching the head up to the tail; offered input dropped
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_rob, in_wen, in_preg, in_areg, in_data};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/completion_writeback_buffer.sv
// Writeback/completion stage: NUM_CH independent in-order completion
// channels feeding the ROB and the physical register file.
module completion_writeback_buffer
  import completion_writeback_buffer_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int SLOTS  = 2,
  parameter int DEPTH  = 2,
  parameter int DATA_W = CWB_DATA_W,
  parameter int PR_W   = CWB_PR_W,
  parameter int AR_W   = CWB_AR_W,
  parameter int ROB_W  = CWB_ROB_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NUM_CH-1:0]                 in_valid,
  output logic [NUM_CH-1:0]                 in_ready,
  input  logic [NUM_CH*ROB_W-1:0]           in_rob,
  input  logic [NUM_CH*SLOTS-1:0]           in_wen,
  input  logic [NUM_CH*SLOTS*PR_W-1:0]      in_preg,
  input  logic [NUM_CH*SLOTS*AR_W-1:0]      in_areg,
  input  logic [NUM_CH*SLOTS*DATA_W-1:0]    in_data,
  output logic [NUM_CH-1:0]                 out_valid,
  input  logic [NUM_CH-1:0]                 out_ready,
  output logic [NUM_CH*ROB_W-1:0]           out_rob,
  output logic [NUM_CH*SLOTS*PR_W-1:0]      out_preg,
  output logic [NUM_CH*SLOTS*AR_W-1:0]      out_areg,
  output logic [NUM_CH*SLOTS*DATA_W-1:0]    out_data,
  output logic [NUM_CH*SLOTS-1:0]           rf_wen,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] occupancy
);

  localparam int OW = occ_w(DEPTH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int SB = slot_idx(c, 0, SLOTS);

    wb_channel_fifo #(
      .DEPTH  (DEPTH),
      .SLOTS  (SLOTS),
      .DATA_W (DATA_W),
      .PR_W   (PR_W),
      .AR_W   (AR_W),
      .ROB_W  (ROB_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid[c]),
      .in_ready  (in_ready[c]),
      .in_rob    (in_rob[c*ROB_W +: ROB_W]),
      .in_wen    (in_wen[SB +: SLOTS]),
      .in_preg   (in_preg[SB*PR_W +: SLOTS*PR_W]),
      .in_areg   (in_areg[SB*AR_W +: SLOTS*AR_W]),
      .in_data   (in_data[SB*DATA_W +: SLOTS*DATA_W]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .out_rob   (out_rob[c*ROB_W +: ROB_W]),
      .out_preg  (out_preg[SB*PR_W +: SLOTS*PR_W]),
      .out_areg  (out_areg[SB*AR_W +: SLOTS*AR_W]),
      .out_data  (out_data[SB*DATA_W +: SLOTS*DATA_W]),
      .rf_wen    (rf_wen[SB +: SLOTS]),
      .occupancy (occupancy[c*OW +: OW])
    );
  end

endmodule

// File: tb/tb_completion_writeback_buffer.sv
// Directed-vector bench for the completion writeback buffer.
module tb_completion_writeback_buffer;

  localparam int NUM_CH = 3;
  localparam int SLOTS  = 2;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 8;
  localparam int PR_W   = 5;
  localparam int AR_W   = 4;
  localparam int ROB_W  = 5;
  localparam int OW     = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  logic flush;
  logic [NUM_CH-1:0]              in_valid;
  logic [NUM_CH-1:0]              in_ready;
  logic [NUM_CH*ROB_W-1:0]        in_rob;
  logic [NUM_CH*SLOTS-1:0]        in_wen;
  logic [NUM_CH*SLOTS*PR_W-1:0]   in_preg;
  logic [NUM_CH*SLOTS*AR_W-1:0]   in_areg;
  logic [NUM_CH*SLOTS*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]              out_valid;
  logic [NUM_CH-1:0]              out_ready;
  logic [NUM_CH*ROB_W-1:0]        out_rob;
  logic [NUM_CH*SLOTS*PR_W-1:0]   out_preg;
  logic [NUM_CH*SLOTS*AR_W-1:0]   out_areg;
  logic [NUM_CH*SLOTS*DATA_W-1:0] out_data;
  logic [NUM_CH*SLOTS-1:0]        rf_wen;
  logic [NUM_CH*OW-1:0]           occupancy;

  logic [ROB_W-1:0]  rob_a  [NUM_CH];
  logic [SLOTS-1:0]  wen_a  [NUM_CH];
  logic [PR_W-1:0]   preg_a [NUM_CH][SLOTS];
  logic [AR_W-1:0]   areg_a [NUM_CH][SLOTS];
  logic [DATA_W-1:0] data_a [NUM_CH][SLOTS];

  int nvec = 0;
  int nerr = 0;

  completion_writeback_buffer #(
    .NUM_CH (NUM_CH),
    .SLOTS  (SLOTS),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .PR_W   (PR_W),
    .AR_W   (AR_W),
    .ROB_W  (ROB_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rob    (in_rob),
    .in_wen    (in_wen),
    .in_preg   (in_preg),
    .in_areg   (in_areg),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rob   (out_rob),
    .out_preg  (out_preg),
    .out_areg  (out_areg),
    .out_data  (out_data),
    .rf_wen    (rf_wen),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_rob  = '0;
    in_wen  = '0;
    in_preg = '0;
    in_areg = '0;
    in_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_rob[c*ROB_W +: ROB_W] = rob_a[c];
      in_wen[c*SLOTS +: SLOTS] = wen_a[c];
      for (int s = 0; s < SLOTS; s++) begin
        in_preg[(c*SLOTS+s)*PR_W +: PR_W]     = preg_a[c][s];
        in_areg[(c*SLOTS+s)*AR_W +: AR_W]     = areg_a[c][s];
        in_data[(c*SLOTS+s)*DATA_W +: DATA_W] = data_a[c][s];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int c, input int rob, input logic [1:0] wen,
                       input int p0, input int d0);
    in_valid[c] = 1'b1;
    rob_a[c]    = ROB_W'(rob);
    wen_a[c]    = wen;
    preg_a[c][0] = PR_W'(p0);
    preg_a[c][1] = PR_W'(p0 + 1);
    areg_a[c][0] = AR_W'(c);
    areg_a[c][1] = AR_W'(c + 8);
    data_a[c][0] = DATA_W'(d0);
    data_a[c][1] = DATA_W'(d0) ^ 8'hFF;
  endtask

  function automatic logic [31:0] o_rob(input int c);
    return 32'(out_rob[c*ROB_W +: ROB_W]);
  endfunction

  function automatic logic [31:0] o_preg(input int c, input int s);
    return 32'(out_preg[(c*SLOTS+s)*PR_W +: PR_W]);
  endfunction

  function automatic logic [31:0] o_data(input int c, input int s);
    return 32'(out_data[(c*SLOTS+s)*DATA_W +: DATA_W]);
  endfunction

  function automatic logic [31:0] rfw(input int c);
    return 32'(rf_wen[c*SLOTS +: SLOTS]);
  endfunction

  function automatic logic [31:0] occ(input int c);
    return 32'(occupancy[c*OW +: OW]);
  endfunction

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int c = 0; c < NUM_CH; c++) offer(c, 0, 2'b00, 0, 0);
    in_valid = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_iready", 32'(in_ready), 32'b111);
    check("rst_rfwen", 32'(rf_wen), 32'd0);

    // single push on ch0
    offer(0, 5, 2'b01, 7, 8'h3C);
    out_ready[0] = 1'b1;
    #1;
    check("ch0_nobypass", 32'(out_valid[0]), 32'd0);
    step();
    in_valid[0] = 1'b0;
    #1;
    check("ch0_valid", 32'(out_valid[0]), 32'd1);
    check("ch0_rob", o_rob(0), 32'd5);
    check("ch0_preg0", o_preg(0, 0), 32'd7);
    check("ch0_data0", o_data(0, 0), 32'h3C);
    check("ch0_data1", o_data(0, 1), 32'hC3);
    check("ch0_rfwen", rfw(0), 32'b01);
    check("ch0_occ1", occ(0), 32'd1);
    step();
    check("ch0_occ0", occ(0), 32'd0);
    check("ch0_rfwen0", rfw(0), 32'd0);
    out_ready[0] = 1'b0;

    // ch1 fill past capacity under backpressure
    offer(1, 1, 2'b11, 3, 8'h11);
    step();
    offer(1, 2, 2'b10, 4, 8'h22);
    step();
    offer(1, 3, 2'b01, 5, 8'h33);
    #1;
    check("ch1_full_rdy", 32'(in_ready[1]), 32'd0);
    check("ch1_full_occ", occ(1), 32'd2);
    step();
    check("ch1_hold_occ", occ(1), 32'd2);
    check("ch1_hold_rob", o_rob(1), 32'd1);
    out_ready[1] = 1'b1;
    #1;
    check("ch1_popfull_rdy", 32'(in_ready[1]), 32'd0);
    check("ch1_rfw1", rfw(1), 32'b11);
    step();
    check("ch1_rob2", o_rob(1), 32'd2);
    check("ch1_occ_a", occ(1), 32'd1);
    check("ch1_rdy_again", 32'(in_ready[1]), 32'd1);
    check("ch1_rfw2", rfw(1), 32'b10);
    step();
    in_valid[1] = 1'b0;
    #1;
    check("ch1_rob3", o_rob(1), 32'd3);
    check("ch1_occ_b", occ(1), 32'd1);
    check("ch1_rfw3", rfw(1), 32'b01);
    step();
    check("ch1_empty", occ(1), 32'd0);
    check("ch1_ovalid0", 32'(out_valid[1]), 32'd0);
    out_ready[1] = 1'b0;

    // ch2 streaming push+pop at occupancy 1
    offer(2, 10, 2'b10, 9, 8'h40);
    step();
    for (int i = 0; i < 10; i++) begin
      offer(2, 11 + i, 2'b10, 9, 8'h41 + i);
      out_ready[2] = 1'b1;
      #1;
      check("ch2_rob", o_rob(2), 32'(10 + i));
      check("ch2_rfw", rfw(2), 32'b10);
      step();
      check("ch2_occ", occ(2), 32'd1);
    end
    in_valid[2] = 1'b0;
    #1;
    check("ch2_last", o_rob(2), 32'd20);
    step();
    check("ch2_empty", occ(2), 32'd0);
    out_ready[2] = 1'b0;

    // fill all, then flush with inputs offered
    for (int c = 0; c < NUM_CH; c++) offer(c, 20 + c, 2'b11, 1, 8'h50);
    step();
    for (int c = 0; c < NUM_CH; c++) offer(c, 24 + c, 2'b11, 2, 8'h60);
    step();
    for (int c = 0; c < NUM_CH; c++) begin
      check("fill_occ", occ(c), 32'd2);
      offer(c, 30 + c, 2'b11, 3, 8'h70);
    end
    flush = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    check("flush_rfw", rfw(0), 32'b11);
    step();
    flush    = 1'b0;
    in_valid = '0;
    #1;
    check("flush_ovalid", 32'(out_valid), 32'd0);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_irdy", 32'(in_ready), 32'b111);
    check("flush_rfwen", 32'(rf_wen), 32'd0);
    step();
    check("flush_nodrop", 32'(out_valid), 32'd0);
    out_ready = '0;

    // stall ch0 with a valid head
    offer(0, 7, 2'b11, 12, 8'h99);
    step();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rfw", rfw(0), 32'd0);
      check("stall_valid", 32'(out_valid[0]), 32'd1);
      step();
    end
    out_ready[0] = 1'b1;
    #1;
    check("release_rfw", rfw(0), 32'b11);
    check("release_rob", o_rob(0), 32'd7);
    step();
    check("release_once", rfw(0), 32'd0);
    check("release_occ", occ(0), 32'd0);
    out_ready[0] = 1'b0;

    // reset during traffic
    offer(0, 1, 2'b11, 1, 8'h01);
    offer(1, 2, 2'b11, 2, 8'h02);
    out_ready = 3'b010;
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = '0;
    #1;
    check("mrst_ovalid", 32'(out_valid), 32'd0);
    check("mrst_occ", 32'(occupancy), 32'd0);
    check("mrst_irdy", 32'(in_ready), 32'b111);
    check("mrst_rfwen", 32'(rf_wen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
